// File: rtl/uart_rx_deserializer_if.sv
// Receiver-side bundle: serial pin in, byte holding register and status pulses out.
interface uart_rx_deserializer_if;
    logic       rx;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    modport master (
        input  rx,
        input  data_ack,
        output data_out,
        output data_valid,
        output parity_error,
        output frame_error,
        output overrun,
        output busy
    );

    modport slave (
        output rx,
        output data_ack,
        input  data_out,
        input  data_valid,
        input  parity_error,
        input  frame_error,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// Oversampling 8E1 UART receiver: mid-bit sampling, parity/stop checking,
// single-entry valid/ack holding register for the downstream consumer.
module uart_rx_deserializer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                   clock,
    input  logic                   reset,
    uart_rx_deserializer_if.master bus
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic             r_sync1;
    logic             r_rx_s;
    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_par_acc;
    logic             r_par_ok;
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_parity_error;
    logic             r_frame_error;
    logic             r_overrun;
    logic             r_busy;

    logic             w_bit_end;
    logic             w_data_tick;
    logic             w_load;
    logic             w_perr;
    logic             w_ferr;
    logic             w_ovr;

    // Two-flop synchroniser; the FSM only ever looks at r_rx_s
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    assign w_bit_end   = (r_cnt == BIT_LAST);
    assign w_data_tick = (r_state == S_DATA) && w_bit_end;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (!r_rx_s) w_state_next = S_START;
            S_START:  if (r_cnt == HALF_LAST) w_state_next = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = S_PARITY;
            S_PARITY: if (w_bit_end) w_state_next = S_STOP;
            S_STOP:   if (w_bit_end) w_state_next = r_rx_s ? S_IDLE : S_BREAK;
            S_BREAK:  if (r_rx_s) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Stop-bit verdict; a same-cycle ack frees the holding register for the new byte
    always_comb begin
        w_load = 1'b0;
        w_perr = 1'b0;
        w_ferr = 1'b0;
        w_ovr  = 1'b0;
        if ((r_state == S_STOP) && w_bit_end) begin
            if (!r_rx_s)                           w_ferr = 1'b1;
            else if (!r_par_ok)                    w_perr = 1'b1;
            else if (!r_data_valid || bus.data_ack) w_load = 1'b1;
            else                                   w_ovr  = 1'b1;
        end
    end

    // Baud counter restarts on every state change and at each data bit boundary
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((w_state_next != r_state) || w_data_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_par_acc <= 1'b0;
            r_par_ok  <= 1'b0;
        end else begin
            if ((r_state == S_START) && (w_state_next == S_DATA)) begin
                r_bit_idx <= 3'd0;
                r_par_acc <= 1'b0;
            end else if (w_data_tick) begin
                r_shift[r_bit_idx] <= r_rx_s;
                r_par_acc          <= r_par_acc ^ r_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
            if ((r_state == S_PARITY) && w_bit_end) r_par_ok <= (r_rx_s == r_par_acc);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data_out     <= 8'd0;
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
            r_overrun      <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            if (w_load) begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
            end else if (bus.data_ack) begin
                r_data_valid <= 1'b0;
            end
            r_parity_error <= w_perr;
            r_frame_error  <= w_ferr;
            r_overrun      <= w_ovr;
            r_busy         <= (w_state_next != S_IDLE);
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.data_valid   = r_data_valid;
    assign bus.parity_error = r_parity_error;
    assign bus.frame_error  = r_frame_error;
    assign bus.overrun      = r_overrun;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer with CLKS_PER_BIT=8: table of frames
// plus hand sequences for break, glitch and mid-frame reset.
module tb_uart_rx_deserializer;

    localparam int unsigned CPB = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    uart_rx_deserializer_if u_if ();

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       ack_before;
        logic       ack_at_stop;
        logic       exp_dv;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ovr;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   ferr_cnt = 0;
    int   perr_cnt = 0;
    int   ovr_cnt  = 0;
    logic exp_dv   = 1'b0;

    // Each one-cycle pulse is seen by exactly one falling edge
    always @(negedge clock) begin
        if (u_if.frame_error)  ferr_cnt = ferr_cnt + 1;
        if (u_if.parity_error) perr_cnt = perr_cnt + 1;
        if (u_if.overrun)      ovr_cnt  = ovr_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drives start, data LSB-first, parity, one bit per CPB clocks, from a falling edge
    task automatic drive_bits(input logic [7:0] d, input logic par, input int nbits);
        logic [9:0] fr;
        fr = {par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            u_if.rx = fr[i];
            repeat (CPB) @(negedge clock);
        end
    endtask

    // Pin drops at falling edge N0; stop sample falls in cycle N0+86, result visible at N0+87
    task automatic run_vec(input vec_t v, input int idx);
        if (v.ack_before) begin
            u_if.data_ack = 1'b1;
            @(negedge clock);
            u_if.data_ack = 1'b0;
            @(negedge clock);
            exp_dv = 1'b0;
            chk($sformatf("v%0d_ack_clears", idx), 32'(u_if.data_valid), 32'(exp_dv));
        end
        drive_bits(v.data, v.par, 10);
        u_if.rx = 1'b1;
        repeat (6) @(negedge clock);
        chk($sformatf("v%0d_dv_before", idx), 32'(u_if.data_valid), 32'(exp_dv));
        if (v.ack_at_stop) u_if.data_ack = 1'b1;
        @(negedge clock);
        u_if.data_ack = 1'b0;
        chk($sformatf("v%0d_dv", idx),   32'(u_if.data_valid),   32'(v.exp_dv));
        chk($sformatf("v%0d_data", idx), 32'(u_if.data_out),     32'(v.exp_data));
        chk($sformatf("v%0d_perr", idx), 32'(u_if.parity_error), 32'(v.exp_perr));
        chk($sformatf("v%0d_ferr", idx), 32'(u_if.frame_error),  32'd0);
        chk($sformatf("v%0d_ovr", idx),  32'(u_if.overrun),      32'(v.exp_ovr));
        chk($sformatf("v%0d_busy", idx), 32'(u_if.busy),         32'd0);
        exp_dv = v.exp_dv;
        @(negedge clock);
        chk($sformatf("v%0d_pulses_clear", idx),
            32'({u_if.parity_error, u_if.frame_error, u_if.overrun}), 32'd0);
    endtask

    vec_t tbl [6];
    vec_t v5a;

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[2] = '{8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[3] = '{8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
        tbl[4] = '{8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0};
        tbl[5] = '{8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0};
        v5a    = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};

        u_if.rx       = 1'b1;
        u_if.data_ack = 1'b0;
        reset         = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_dv",     32'(u_if.data_valid), 32'd0);
        chk("rst_data",   32'(u_if.data_out),   32'd0);
        chk("rst_busy",   32'(u_if.busy),       32'd0);
        chk("rst_pulses", 32'({u_if.parity_error, u_if.frame_error, u_if.overrun}), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);
        chk("tbl_perr_cnt", 32'(perr_cnt), 32'd1);
        chk("tbl_ovr_cnt",  32'(ovr_cnt),  32'd1);

        // Bad stop bit followed by a line held low: one frame_error, then wait in BREAK
        repeat (3) @(negedge clock);
        drive_bits(8'h3C, 1'b0, 10);
        u_if.rx = 1'b0;
        repeat (7) @(negedge clock);
        chk("brk_ferr",      32'(u_if.frame_error), 32'd1);
        chk("brk_busy",      32'(u_if.busy),        32'd1);
        chk("brk_dv_kept",   32'(u_if.data_valid),  32'd1);
        chk("brk_data_kept", 32'(u_if.data_out),    32'h44);
        repeat (41) @(negedge clock);
        chk("brk_busy_held", 32'(u_if.busy), 32'd1);
        chk("brk_ferr_once", 32'(ferr_cnt),  32'd1);
        u_if.rx = 1'b1;
        repeat (4) @(negedge clock);
        chk("brk_idle", 32'(u_if.busy), 32'd0);
        repeat (90) @(negedge clock);
        chk("brk_no_phantom", 32'({ferr_cnt[7:0], perr_cnt[7:0], ovr_cnt[7:0]}), 32'h010101);
        chk("brk_data_final", 32'(u_if.data_out), 32'h44);

        // Two-clock low glitch: false start, no output change
        u_if.rx = 1'b0;
        repeat (2) @(negedge clock);
        u_if.rx = 1'b1;
        repeat (2) @(negedge clock);
        chk("glitch_busy", 32'(u_if.busy), 32'd1);
        repeat (4) @(negedge clock);
        chk("glitch_idle", 32'(u_if.busy), 32'd0);
        chk("glitch_outs", 32'({u_if.data_valid, u_if.data_out}), 32'h144);
        chk("glitch_no_pulse", 32'({ferr_cnt[7:0], perr_cnt[7:0], ovr_cnt[7:0]}), 32'h010101);

        // Asynchronous reset in the middle of bit 4, then a clean frame
        drive_bits(8'h5A, 1'b0, 5);
        #2 reset = 1'b1;
        #1;
        chk("amid_rst_dv",   32'(u_if.data_valid), 32'd0);
        chk("amid_rst_data", 32'(u_if.data_out),   32'd0);
        chk("amid_rst_busy", 32'(u_if.busy),       32'd0);
        @(negedge clock);
        repeat (2) @(negedge clock);
        u_if.rx = 1'b1;
        reset   = 1'b0;
        repeat (4) @(negedge clock);
        exp_dv = 1'b0;
        run_vec(v5a, 6);
        chk("final_counts", 32'({ferr_cnt[7:0], perr_cnt[7:0], ovr_cnt[7:0]}), 32'h010101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
